// File: rtl/muldiv_sequencer_pkg.sv
// Shared CPU control definitions for the mult/div sequencer: state encodings,
// iteration count, operation codes and the Moore output decode.
package muldiv_sequencer_pkg;

  localparam int MD_STEPS = 32;
  localparam int MD_CNTW  = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4,
    S_DZERO = 3'd5
  } md_state_t;

  typedef struct packed {
    logic unit_init;
    logic unit_step;
    logic fix_sign;
    logic hilo_write;
    logic mult_stop;
    logic div_stop;
    logic div_zero;
    logic busy;
  } md_out_t;

  // Each state owns at most one unit command and at most one completion pulse.
  function automatic md_out_t md_decode(input md_state_t st, input logic op);
    md_out_t o;
    o = '0;
    case (st)
      S_IDLE:  o.busy = 1'b0;
      S_INIT:  begin o.unit_init = 1'b1; o.busy = 1'b1; end
      S_RUN:   begin o.unit_step = 1'b1; o.busy = 1'b1; end
      S_FIX:   begin o.fix_sign  = 1'b1; o.busy = 1'b1; end
      S_DONE:  begin
        o.hilo_write = 1'b1;
        o.mult_stop  = (op == OP_MULT);
        o.div_stop   = (op == OP_DIV);
        o.busy       = 1'b1;
      end
      S_DZERO: begin o.div_zero = 1'b1; o.busy = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_step_counter.sv
// Iteration counter for the mult/div sequencer: clears, counts up on enable and
// flags the last iteration; it saturates there instead of wrapping.
module step_counter
  import muldiv_sequencer_pkg::*;
#(
  parameter int STEPS = MD_STEPS,
  parameter int CNTW  = MD_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  output logic [CNTW-1:0] count,
  output logic            tc
);

  logic [CNTW-1:0] count_r;
  logic            tc_s;

  assign tc_s  = (count_r == CNTW'(STEPS - 1));
  assign count = count_r;
  assign tc    = tc_s;

  // Iteration index register; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {CNTW{1'b0}};
    end else if (clear) begin
      count_r <= {CNTW{1'b0}};
    end else if (enable && !tc_s) begin
      count_r <= count_r + CNTW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Moore sequencer for the shared iterative mult/div unit. Outputs are registered
// from the next state so each one lines up with the state that owns it.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int STEPS = MD_STEPS,
  parameter int CNTW  = MD_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MultCtrl,
  input  logic            DivCtrl,
  input  logic            DivisorZero,
  output logic            UnitInit,
  output logic            UnitStep,
  output logic            UnitOp,
  output logic            FixSign,
  output logic            HILOWrite,
  output logic            MultStop,
  output logic            DivStop,
  output logic            DivZero,
  output logic            Busy,
  output logic [CNTW-1:0] StepCount
);

  md_state_t state_r;
  md_state_t next_state_s;
  logic      op_r;
  logic      next_op_s;
  md_out_t   out_r;
  logic      cnt_clear_s;
  logic      cnt_enable_s;
  logic      cnt_tc_s;

  // Next-state and operation latch; requests only count in IDLE, multiply first.
  always_comb begin
    next_state_s = state_r;
    next_op_s    = op_r;
    case (state_r)
      S_IDLE: begin
        if (MultCtrl) begin
          next_state_s = S_INIT;
          next_op_s    = OP_MULT;
        end else if (DivCtrl && DivisorZero) begin
          next_state_s = S_DZERO;
        end else if (DivCtrl) begin
          next_state_s = S_INIT;
          next_op_s    = OP_DIV;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_INIT: next_state_s = S_RUN;
      S_RUN: begin
        if (cnt_tc_s) begin
          next_state_s = (op_r == OP_DIV) ? S_FIX : S_DONE;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_FIX:   next_state_s = S_DONE;
      S_DONE:  next_state_s = S_IDLE;
      S_DZERO: next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Counter holds zero outside RUN and advances only between RUN cycles.
  always_comb begin
    cnt_clear_s  = (next_state_s != S_RUN);
    cnt_enable_s = (next_state_s == S_RUN) && (state_r == S_RUN);
  end

  // State, operation and decoded output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
      op_r    <= OP_MULT;
      out_r   <= '0;
    end else begin
      state_r <= next_state_s;
      op_r    <= next_op_s;
      out_r   <= md_decode(next_state_s, next_op_s);
    end
  end

  step_counter #(
    .STEPS (STEPS),
    .CNTW  (CNTW)
  ) u_step_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear_s),
    .enable (cnt_enable_s),
    .count  (StepCount),
    .tc     (cnt_tc_s)
  );

  assign UnitInit  = out_r.unit_init;
  assign UnitStep  = out_r.unit_step;
  assign UnitOp    = op_r;
  assign FixSign   = out_r.fix_sign;
  assign HILOWrite = out_r.hilo_write;
  assign MultStop  = out_r.mult_stop;
  assign DivStop   = out_r.div_stop;
  assign DivZero   = out_r.div_zero;
  assign Busy      = out_r.busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: cycle-by-cycle output schedules for
// multiply, divide, divide-by-zero, arbitration, reset abort and back-to-back.
module tb_muldiv_sequencer;

  logic       clk;
  logic       reset;
  logic       MultCtrl;
  logic       DivCtrl;
  logic       DivisorZero;
  logic       UnitInit;
  logic       UnitStep;
  logic       UnitOp;
  logic       FixSign;
  logic       HILOWrite;
  logic       MultStop;
  logic       DivStop;
  logic       DivZero;
  logic       Busy;
  logic [5:0] StepCount;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [14:0] obs_s;
  logic [13:0] obs_noop_s;
  logic [14:0] exp_v;
  logic [13:0] exp_noop_v;

  muldiv_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .MultCtrl    (MultCtrl),
    .DivCtrl     (DivCtrl),
    .DivisorZero (DivisorZero),
    .UnitInit    (UnitInit),
    .UnitStep    (UnitStep),
    .UnitOp      (UnitOp),
    .FixSign     (FixSign),
    .HILOWrite   (HILOWrite),
    .MultStop    (MultStop),
    .DivStop     (DivStop),
    .DivZero     (DivZero),
    .Busy        (Busy),
    .StepCount   (StepCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {init, step, op, fix, hilo, mstop, dstop, dzero, busy, stepcount}
  assign obs_s = {UnitInit, UnitStep, UnitOp, FixSign, HILOWrite, MultStop,
                  DivStop, DivZero, Busy, StepCount};
  assign obs_noop_s = {obs_s[14:13], obs_s[11:0]};

  // Expected outputs in cycle c after a start edge (default STEPS = 32).
  function automatic logic [14:0] exp_vec(input int c, input logic div);
    logic init, step, fix, hilo, ms, ds, busy;
    logic [5:0] sc;
    int last;
    init = 1'b0; step = 1'b0; fix = 1'b0; hilo = 1'b0;
    ms = 1'b0; ds = 1'b0; sc = 6'd0;
    last = div ? 35 : 34;
    if (c == 1) init = 1'b1;
    else if (c >= 2 && c <= 33) begin step = 1'b1; sc = 6'(c - 2); end
    else if (div && c == 34) fix = 1'b1;
    if (c == last) begin hilo = 1'b1; ms = !div; ds = div; end
    busy = (c >= 1 && c <= last);
    return {init, step, div, fix, hilo, ms, ds, 1'b0, busy, sc};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; MultCtrl = 1'b1; DivCtrl = 1'b0; DivisorZero = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_s !== 15'd0) begin
        fails++;
        $display("FAIL reset[%0d]: got %b expected %b", i, obs_s, 15'd0);
      end else passed++;
      tick();
    end
  endtask

  // Start request present at the very edge where reset is first released.
  task automatic test_first_start();
    reset = 1'b1; MultCtrl = 1'b1;
    tick();
    MultCtrl = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      if (c > 1) tick();
      exp_v = exp_vec(c, 1'b0);
      checks++;
      if (obs_s !== exp_v) begin
        fails++;
        $display("FAIL first_start cycle %0d: got %b expected %b", c, obs_s, exp_v);
      end else passed++;
    end
  endtask

  task automatic test_mult();
    MultCtrl = 1'b1;
    tick();
    MultCtrl = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      if (c > 1) tick();
      exp_v = exp_vec(c, 1'b0);
      checks++;
      if (obs_s !== exp_v) begin
        fails++;
        $display("FAIL mult cycle %0d: got %b expected %b", c, obs_s, exp_v);
      end else passed++;
    end
  endtask

  task automatic test_div();
    DivCtrl = 1'b1; DivisorZero = 1'b0;
    tick();
    DivCtrl = 1'b0;
    for (int c = 1; c <= 37; c++) begin
      if (c > 1) tick();
      exp_v = exp_vec(c, 1'b1);
      checks++;
      if (obs_s !== exp_v) begin
        fails++;
        $display("FAIL div cycle %0d: got %b expected %b", c, obs_s, exp_v);
      end else passed++;
    end
  endtask

  task automatic test_div_zero();
    DivCtrl = 1'b1; DivisorZero = 1'b1;
    tick();
    DivCtrl = 1'b0; DivisorZero = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      exp_noop_v = (c == 1) ? 14'b00000011000000 : 14'd0;
      checks++;
      if (obs_noop_s !== exp_noop_v) begin
        fails++;
        $display("FAIL div_zero cycle %0d: got %b expected %b", c, obs_noop_s, exp_noop_v);
      end else passed++;
    end
  endtask

  // Simultaneous requests pick multiply; a later divide request is dropped.
  task automatic test_both();
    MultCtrl = 1'b1; DivCtrl = 1'b1;
    tick();
    MultCtrl = 1'b0; DivCtrl = 1'b0;
    for (int c = 1; c <= 37; c++) begin
      if (c > 1) tick();
      exp_v = exp_vec(c, 1'b0);
      checks++;
      if (obs_s !== exp_v) begin
        fails++;
        $display("FAIL both cycle %0d: got %b expected %b", c, obs_s, exp_v);
      end else passed++;
      if (c == 10) begin DivCtrl = 1'b1; DivisorZero = 1'b1; end
      if (c == 11) begin DivCtrl = 1'b0; DivisorZero = 1'b0; end
    end
  endtask

  task automatic test_reset_abort();
    MultCtrl = 1'b1;
    tick();
    MultCtrl = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) tick();
      exp_v = exp_vec(c, 1'b0);
      checks++;
      if (obs_s !== exp_v) begin
        fails++;
        $display("FAIL abort_pre cycle %0d: got %b expected %b", c, obs_s, exp_v);
      end else passed++;
    end
    reset = 1'b0;
    for (int c = 21; c <= 45; c++) begin
      tick();
      if (c == 22) reset = 1'b1;
      checks++;
      if (obs_s !== 15'd0) begin
        fails++;
        $display("FAIL abort cycle %0d: got %b expected %b", c, obs_s, 15'd0);
      end else passed++;
    end
  endtask

  // Request during DONE is ignored; the same request held into IDLE starts.
  task automatic test_back_to_back();
    MultCtrl = 1'b1;
    tick();
    MultCtrl = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c > 1) tick();
      exp_v = exp_vec(c, 1'b0);
      checks++;
      if (obs_s !== exp_v) begin
        fails++;
        $display("FAIL b2b_first cycle %0d: got %b expected %b", c, obs_s, exp_v);
      end else passed++;
      if (c == 34) MultCtrl = 1'b1;
    end
    tick();
    MultCtrl = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      if (c > 1) tick();
      exp_v = exp_vec(c, 1'b0);
      checks++;
      if (obs_s !== exp_v) begin
        fails++;
        $display("FAIL b2b_second cycle %0d: got %b expected %b", c, obs_s, exp_v);
      end else passed++;
    end
  endtask

  initial begin
    reset = 1'b0; MultCtrl = 1'b0; DivCtrl = 1'b0; DivisorZero = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_start();
    test_mult();
    test_div();
    test_div_zero();
    test_both();
    test_reset_abort();
    test_mult();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter STEPS, default 32, is the number of iteration cycles of the shared mult/div unit.
REQ-002 Parameter CNTW, default 6, is the width of StepCount and SHALL satisfy 2^CNTW > STEPS.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 MultCtrl  input  1  multiply start request from control_unit, sampled on each rising edge.
REQ-006 DivCtrl  input  1  divide start request from control_unit, sampled on each rising edge.
REQ-007 DivisorZero  input  1  divisor operand equals zero; valid in the cycle DivCtrl is asserted.
REQ-008 UnitInit  output  1  load operands into the iterative unit.
REQ-009 UnitStep  output  1  perform one iteration in the unit.
REQ-010 UnitOp  output  1  operation select: 0 = multiply, 1 = divide; held stable for the whole operation.
REQ-011 FixSign  output  1  apply the divide sign correction.
REQ-012 HILOWrite  output  1  write the unit result into HI/LO.
REQ-013 MultStop  output  1  one-cycle multiply-complete pulse.
REQ-014 DivStop  output  1  one-cycle divide-complete pulse.
REQ-015 DivZero  output  1  one-cycle divide-by-zero exception pulse.
REQ-016 Busy  output  1  high while any operation is in progress.
REQ-017 StepCount  output  CNTW  current iteration index.

Function
REQ-018 The block SHALL implement a Moore FSM with states IDLE, INIT, RUN, FIX, DONE and DZERO; all outputs are decoded from registered state.
REQ-019 IDLE SHALL move to INIT when MultCtrl=1, with UnitOp latched to 0.
REQ-020 IDLE SHALL move to INIT when DivCtrl=1 and DivisorZero=0, with UnitOp latched to 1.
REQ-021 IDLE SHALL move to DZERO when DivCtrl=1 and DivisorZero=1.
REQ-022 If MultCtrl and DivCtrl are asserted together, multiply SHALL win and the divide request SHALL be dropped.
REQ-023 INIT SHALL assert UnitInit=1, clear StepCount to 0, and move to RUN after one cycle.
REQ-024 RUN SHALL assert UnitStep=1 and increment StepCount each cycle.
REQ-025 RUN SHALL exit when StepCount==STEPS-1: to FIX if UnitOp=1, else to DONE; StepCount SHALL never wrap.
REQ-026 FIX SHALL assert FixSign=1 for exactly one cycle, then move to DONE.
REQ-027 DONE SHALL assert HILOWrite=1 for one cycle, plus MultStop=1 (UnitOp=0) or DivStop=1 (UnitOp=1), then return to IDLE.
REQ-028 DZERO SHALL assert DivZero=1 for one cycle, with no UnitInit, UnitStep or HILOWrite, then return to IDLE.
REQ-029 Busy SHALL be 1 in every state except IDLE.
REQ-030 MultCtrl and DivCtrl SHALL be ignored while Busy=1; no request is queued.
REQ-031 A request arriving in the same cycle as DONE or DZERO SHALL be ignored, since the FSM is not yet in IDLE.
REQ-032 Latency SHALL be measured from the start edge t:
- multiply: HILOWrite/MultStop in cycle t+STEPS+2 (34 with default STEPS);
- divide: HILOWrite/DivStop in cycle t+STEPS+3 (35);
- divide by zero: DivZero in cycle t+1.
REQ-033 At most one of UnitInit, UnitStep, FixSign and HILOWrite SHALL be high in any cycle.
REQ-034 At most one of MultStop, DivStop and DivZero SHALL be high in any cycle.

Reset
REQ-035 When reset=0 at a rising edge, the FSM SHALL enter IDLE regardless of its current state, including mid-RUN.
REQ-036 During and after reset, all 1-bit outputs SHALL be 0, StepCount SHALL be 0 and UnitOp SHALL be 0.
REQ-037 An operation aborted by reset SHALL never produce HILOWrite or any Stop/DivZero pulse.
REQ-038 The first start is accepted at the first rising edge at which reset=1.

Structure
REQ-039 State encodings, STEPS and the UnitOp codes (OP_MULT=0, OP_DIV=1) SHALL live in the shared CPU control package used by control_unit.
REQ-040 The iteration counter SHALL be a sub-module, step_counter, with clear, enable and a terminal-count output; the FSM instantiates it once.
REQ-041 The block SHALL contain no datapath arithmetic; it only sequences the external mult/div unit.

Verification
REQ-042 MultCtrl pulse at edge 0 -> UnitInit at cycle 1; UnitStep cycles 2-33 with StepCount 0-31; HILOWrite and MultStop at cycle 34; Busy falls at cycle 35.
REQ-043 DivCtrl=1, DivisorZero=0 at edge 0 -> FixSign at cycle 34; HILOWrite and DivStop at cycle 35; UnitOp=1 throughout.
REQ-044 DivCtrl=1, DivisorZero=1 -> DivZero=1 at cycle 1 only; UnitInit and HILOWrite stay 0; Busy=0 at cycle 2.
REQ-045 MultCtrl and DivCtrl together -> multiply sequence (UnitOp=0, MultStop at 34); an extra DivCtrl at cycle 10 is ignored and no DivStop occurs.
REQ-046 reset=0 at cycle 20 of a multiply -> all outputs 0 from cycle 21; no HILOWrite; a new MultCtrl after reset release completes normally at +34.
REQ-047 Back-to-back multiplies: MultCtrl asserted in the DONE cycle is ignored; MultCtrl at the next cycle (IDLE) is accepted.
